// File: rtl/mfi_check_pkg.sv
// Shared types for the MFI multi-retire sequential consistency checker.
package mfi_check_pkg;

  localparam int unsigned MfiXlen = 32;
  localparam int unsigned MfiAw   = 4;
  localparam int unsigned MfiCntw = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArm   = 2'd1,
    StTrack = 2'd2,
    StDone  = 2'd3
  } chk_state_e;

  typedef enum logic [1:0] {
    FailNone = 2'd0,
    FailSrc1 = 2'd1,
    FailSrc2 = 2'd2,
    FailPc   = 2'd3
  } fail_code_e;

  typedef struct packed {
    chk_state_e           state;
    logic [MfiCntw-1:0]   counter;
    logic                 shadow_vld;
    logic [MfiAw-1:0]     shadow_addr;
    logic [MfiXlen-1:0]   shadow_data;
    logic [MfiXlen-1:0]   last_pc;
  } trk_t;

endpackage

// File: rtl/mfi_retire_slot.sv
// Combinational per-channel step of the checker: applies one retirement to the tracking state.
// PC continuity checking is compiled in with MFI_PC_CHAIN_EN.
module mfi_retire_slot
  import mfi_check_pkg::*;
#(
  parameter int unsigned TrackLen = 16
) (
  input  trk_t                 i_trk,
  input  logic                 i_valid,
  input  logic                 i_trap,
  input  logic [MfiAw-1:0]     i_src1_addr,
  input  logic [MfiAw-1:0]     i_src2_addr,
  input  logic [MfiAw-1:0]     i_dest_addr,
  input  logic [MfiXlen-1:0]   i_src1_rdata,
  input  logic [MfiXlen-1:0]   i_src2_rdata,
  input  logic [MfiXlen-1:0]   i_dest_wdata,
  input  logic [MfiXlen-1:0]   i_pc_rdata,
  input  logic [MfiXlen-1:0]   i_pc_wdata,
  output trk_t                 o_trk,
  output fail_code_e           o_fail
);

`ifndef MFI_PC_CHAIN_EN
  logic w_unused_pc;
  assign w_unused_pc = ^{i_pc_rdata, i_pc_wdata, i_trk.last_pc};
`endif

  always_comb begin
    o_trk  = i_trk;
    o_fail = FailNone;
    if (i_valid && !i_trap) begin
      case (i_trk.state)
        StArm: begin
          if (i_trk.counter != '0) begin
            o_trk.counter = i_trk.counter - 1'b1;
          end else begin
            o_trk.state      = StTrack;
            o_trk.counter    = MfiCntw'(TrackLen);
            // x0 captures leave nothing to shadow
            o_trk.shadow_vld = (i_dest_addr != '0);
            if (i_dest_addr != '0) begin
              o_trk.shadow_addr = i_dest_addr;
              o_trk.shadow_data = i_dest_wdata;
            end
`ifdef MFI_PC_CHAIN_EN
            o_trk.last_pc = i_pc_wdata;
`endif
          end
        end
        StTrack: begin
          if (i_trk.shadow_vld && (i_src1_addr == i_trk.shadow_addr) &&
              (i_src1_rdata != i_trk.shadow_data)) begin
            o_fail = FailSrc1;
          end else if (i_trk.shadow_vld && (i_src2_addr == i_trk.shadow_addr) &&
                       (i_src2_rdata != i_trk.shadow_data)) begin
            o_fail = FailSrc2;
          end
          if (i_dest_addr == i_trk.shadow_addr) begin
            o_trk.shadow_vld = 1'b0;
          end
`ifdef MFI_PC_CHAIN_EN
          if ((o_fail == FailNone) && (i_pc_rdata != i_trk.last_pc)) begin
            o_fail = FailPc;
          end
          o_trk.last_pc = i_pc_wdata;
`endif
          if (i_trk.counter <= MfiCntw'(1)) begin
            o_trk.counter = '0;
            o_trk.state   = StDone;
          end else begin
            o_trk.counter = i_trk.counter - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mfi_seq_check.sv
// Multi-retire sequential consistency checker: chains NRET retire slots and registers the result.
// Optional PC continuity check enabled by defining MFI_PC_CHAIN_EN.
module mfi_seq_check
  import mfi_check_pkg::*;
#(
  parameter int unsigned NRET      = 2,
  parameter int unsigned XLEN      = MfiXlen,
  parameter int unsigned AW        = MfiAw,
  parameter int unsigned CNTW      = MfiCntw,
  parameter int unsigned TRACK_LEN = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    check_trig,
  input  logic [CNTW-1:0]         check_skip,
  input  logic [NRET-1:0]         mfi_valid,
  input  logic [NRET-1:0]         mfi_trap,
  input  logic [NRET*AW-1:0]      mfi_src1_addr,
  input  logic [NRET*AW-1:0]      mfi_src2_addr,
  input  logic [NRET*AW-1:0]      mfi_dest_addr,
  input  logic [NRET*XLEN-1:0]    mfi_src1_rdata,
  input  logic [NRET*XLEN-1:0]    mfi_src2_rdata,
  input  logic [NRET*XLEN-1:0]    mfi_dest_wdata,
  input  logic [NRET*XLEN-1:0]    mfi_pc_rdata,
  input  logic [NRET*XLEN-1:0]    mfi_pc_wdata,
  output logic [1:0]              chk_state,
  output logic                    chk_fail,
  output logic [1:0]              chk_fail_code,
  output logic [((NRET > 1) ? $clog2(NRET) : 1)-1:0] chk_fail_chan,
  output logic [CNTW-1:0]         chk_remain
);

  localparam int unsigned ChanW = (NRET > 1) ? $clog2(NRET) : 1;

  trk_t             r_trk;
  logic             r_fail;
  fail_code_e       r_fail_code;
  logic [ChanW-1:0] r_fail_chan;

  trk_t             w_trk [NRET+1];
  fail_code_e       w_fail [NRET];
  trk_t             w_trk_nxt;
  fail_code_e       w_fail_code;
  logic [ChanW-1:0] w_fail_chan;

  assign w_trk[0] = r_trk;

  for (genvar k = 0; k < NRET; k++) begin : g_slot
    mfi_retire_slot #(
      .TrackLen(TRACK_LEN)
    ) u_slot (
      .i_trk        (w_trk[k]),
      .i_valid      (mfi_valid[k]),
      .i_trap       (mfi_trap[k]),
      .i_src1_addr  (mfi_src1_addr[k*AW +: AW]),
      .i_src2_addr  (mfi_src2_addr[k*AW +: AW]),
      .i_dest_addr  (mfi_dest_addr[k*AW +: AW]),
      .i_src1_rdata (mfi_src1_rdata[k*XLEN +: XLEN]),
      .i_src2_rdata (mfi_src2_rdata[k*XLEN +: XLEN]),
      .i_dest_wdata (mfi_dest_wdata[k*XLEN +: XLEN]),
      .i_pc_rdata   (mfi_pc_rdata[k*XLEN +: XLEN]),
      .i_pc_wdata   (mfi_pc_wdata[k*XLEN +: XLEN]),
      .o_trk        (w_trk[k+1]),
      .o_fail       (w_fail[k])
    );
  end

  // Slots are inert in IDLE/DONE, so a trigger simply overrides the chain result.
  always_comb begin
    w_trk_nxt = w_trk[NRET];
    if (((r_trk.state == StIdle) || (r_trk.state == StDone)) && check_trig) begin
      w_trk_nxt.state      = StArm;
      w_trk_nxt.counter    = check_skip;
      w_trk_nxt.shadow_vld = 1'b0;
    end
  end

  // Lowest channel wins: scan downwards so channel 0 is applied last.
  always_comb begin
    w_fail_code = FailNone;
    w_fail_chan = '0;
    for (int k = int'(NRET) - 1; k >= 0; k--) begin
      if (w_fail[k] != FailNone) begin
        w_fail_code = w_fail[k];
        w_fail_chan = ChanW'(k);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_trk       <= '0;
      r_fail      <= 1'b0;
      r_fail_code <= FailNone;
      r_fail_chan <= '0;
    end else begin
      r_trk <= w_trk_nxt;
      if (!r_fail && (w_fail_code != FailNone)) begin
        r_fail      <= 1'b1;
        r_fail_code <= w_fail_code;
        r_fail_chan <= w_fail_chan;
      end
    end
  end

  assign chk_state     = r_trk.state;
  assign chk_fail      = r_fail;
  assign chk_fail_code = r_fail_code;
  assign chk_fail_chan = r_fail_chan;
  assign chk_remain    = r_trk.counter;

endmodule

// File: tb/tb_mfi_seq_check.sv
// Self-checking bench for mfi_seq_check: directed scenarios plus randomized traffic vs a model.
module tb_mfi_seq_check;

  localparam int unsigned NRET      = 2;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned AW        = 4;
  localparam int unsigned CNTW      = 8;
  localparam int unsigned TRACK_LEN = 16;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic                 check_trig;
  logic [CNTW-1:0]      check_skip;
  logic [NRET-1:0]      mfi_valid, mfi_trap;
  logic [NRET*AW-1:0]   mfi_src1_addr, mfi_src2_addr, mfi_dest_addr;
  logic [NRET*XLEN-1:0] mfi_src1_rdata, mfi_src2_rdata, mfi_dest_wdata;
  logic [NRET*XLEN-1:0] mfi_pc_rdata, mfi_pc_wdata;
  logic [1:0]           chk_state;
  logic                 chk_fail;
  logic [1:0]           chk_fail_code;
  logic [0:0]           chk_fail_chan;
  logic [CNTW-1:0]      chk_remain;

  int checks = 0;
  int failures = 0;
  logic [XLEN-1:0] tb_pc;

  // Reference model: mode 0 idle, 1 arm, 2 track, 3 done
  int              m_mode, m_cnt, m_addr, m_code, m_chan;
  bit              m_vld, m_fail;
  logic [XLEN-1:0] m_data, m_lpc;

  mfi_seq_check #(
    .NRET(NRET), .XLEN(XLEN), .AW(AW), .CNTW(CNTW), .TRACK_LEN(TRACK_LEN)
  ) dut (
    .clock(clock), .reset(reset), .check_trig(check_trig), .check_skip(check_skip),
    .mfi_valid(mfi_valid), .mfi_trap(mfi_trap),
    .mfi_src1_addr(mfi_src1_addr), .mfi_src2_addr(mfi_src2_addr),
    .mfi_dest_addr(mfi_dest_addr), .mfi_src1_rdata(mfi_src1_rdata),
    .mfi_src2_rdata(mfi_src2_rdata), .mfi_dest_wdata(mfi_dest_wdata),
    .mfi_pc_rdata(mfi_pc_rdata), .mfi_pc_wdata(mfi_pc_wdata),
    .chk_state(chk_state), .chk_fail(chk_fail), .chk_fail_code(chk_fail_code),
    .chk_fail_chan(chk_fail_chan), .chk_remain(chk_remain)
  );

  always #5 clock = ~clock;

  task automatic clear_in();
    check_trig = 1'b0; check_skip = '0;
    mfi_valid = '0; mfi_trap = '0;
    mfi_src1_addr = '0; mfi_src2_addr = '0; mfi_dest_addr = '0;
    mfi_src1_rdata = '0; mfi_src2_rdata = '0; mfi_dest_wdata = '0;
    mfi_pc_rdata = '0; mfi_pc_wdata = '0;
  endtask

  task automatic retire(input int ch, input int dest, input logic [XLEN-1:0] wdata,
                        input int s1a, input logic [XLEN-1:0] s1d,
                        input int s2a, input logic [XLEN-1:0] s2d);
    mfi_valid[ch] = 1'b1;
    mfi_dest_addr[ch*AW +: AW]    = AW'(dest);
    mfi_dest_wdata[ch*XLEN +: XLEN] = wdata;
    mfi_src1_addr[ch*AW +: AW]    = AW'(s1a);
    mfi_src1_rdata[ch*XLEN +: XLEN] = s1d;
    mfi_src2_addr[ch*AW +: AW]    = AW'(s2a);
    mfi_src2_rdata[ch*XLEN +: XLEN] = s2d;
    mfi_pc_rdata[ch*XLEN +: XLEN] = tb_pc;
    mfi_pc_wdata[ch*XLEN +: XLEN] = tb_pc + 32'd4;
    tb_pc = tb_pc + 32'd4;
  endtask

  task automatic model_eval();
    int cyc_code, cyc_chan, code, dest, s1a, s2a;
    logic [XLEN-1:0] s1d, s2d, wd, pcr, pcw;
    cyc_code = 0;
    cyc_chan = 0;
    if (!reset) begin
      m_mode = 0; m_cnt = 0; m_vld = 0; m_addr = 0; m_data = '0; m_lpc = '0;
      m_fail = 0; m_code = 0; m_chan = 0;
      return;
    end
    if ((m_mode == 0 || m_mode == 3) && check_trig) begin
      m_mode = 1; m_cnt = int'(check_skip); m_vld = 0;
      return;
    end
    for (int k = 0; k < NRET; k++) begin
      if (!mfi_valid[k] || mfi_trap[k] || m_mode == 0 || m_mode == 3) continue;
      dest = int'(mfi_dest_addr[k*AW +: AW]);
      s1a  = int'(mfi_src1_addr[k*AW +: AW]);
      s2a  = int'(mfi_src2_addr[k*AW +: AW]);
      wd   = mfi_dest_wdata[k*XLEN +: XLEN];
      s1d  = mfi_src1_rdata[k*XLEN +: XLEN];
      s2d  = mfi_src2_rdata[k*XLEN +: XLEN];
      pcr  = mfi_pc_rdata[k*XLEN +: XLEN];
      pcw  = mfi_pc_wdata[k*XLEN +: XLEN];
      if (m_mode == 1) begin
        if (m_cnt > 0) m_cnt--;
        else begin
          m_mode = 2; m_cnt = TRACK_LEN; m_lpc = pcw;
          m_vld = (dest != 0);
          if (dest != 0) begin m_addr = dest; m_data = wd; end
        end
      end else begin
        code = 0;
        if (m_vld && s1a == m_addr && s1d != m_data) code = 1;
        else if (m_vld && s2a == m_addr && s2d != m_data) code = 2;
        if (dest == m_addr) m_vld = 0;
`ifdef MFI_PC_CHAIN_EN
        if (code == 0 && pcr != m_lpc) code = 3;
`endif
        m_lpc = pcw;
        if (code != 0 && cyc_code == 0) begin cyc_code = code; cyc_chan = k; end
        m_cnt--;
        if (m_cnt == 0) m_mode = 3;
      end
    end
    if (!m_fail && cyc_code != 0) begin m_fail = 1; m_code = cyc_code; m_chan = cyc_chan; end
  endtask

  task automatic step();
    model_eval();
    @(posedge clock);
    #1;
    clear_in();
  endtask

  task automatic do_reset();
    reset = 1'b0; step(); reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; step(); step(); reset = 1'b1;
    checks++; if (chk_state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", chk_state); end
    checks++; if (chk_remain !== 8'd0) begin failures++; $display("FAIL reset_remain: got %0d want 0", chk_remain); end
    checks++; if (chk_fail !== 1'b0) begin failures++; $display("FAIL reset_fail: got %0d want 0", chk_fail); end
    checks++; if (chk_fail_code !== 2'd0) begin failures++; $display("FAIL reset_code: got %0d want 0", chk_fail_code); end
    checks++; if (chk_fail_chan !== 1'b0) begin failures++; $display("FAIL reset_chan: got %0d want 0", chk_fail_chan); end
  endtask

  task automatic test_skip();
    do_reset(); tb_pc = 32'h40;
    check_trig = 1'b1; check_skip = 8'd2; step();
    checks++; if (chk_state !== 2'd1 || chk_remain !== 8'd2) begin failures++;
      $display("FAIL skip_arm: got state %0d remain %0d want 1/2", chk_state, chk_remain); end
    retire(0, 3, 32'h11, 0, '0, 0, '0); step();
    checks++; if (chk_state !== 2'd1 || chk_remain !== 8'd1) begin failures++;
      $display("FAIL skip_dec1: got state %0d remain %0d want 1/1", chk_state, chk_remain); end
    retire(0, 5, 32'h22, 0, '0, 0, '0); step();
    checks++; if (chk_state !== 2'd1 || chk_remain !== 8'd0) begin failures++;
      $display("FAIL skip_dec2: got state %0d remain %0d want 1/0", chk_state, chk_remain); end
    retire(0, 7, 32'h33, 0, '0, 0, '0); step();
    checks++; if (chk_state !== 2'd2 || chk_remain !== 8'd16 || chk_fail !== 1'b0) begin failures++;
      $display("FAIL skip_capture: got state %0d remain %0d fail %0d want 2/16/0",
               chk_state, chk_remain, chk_fail); end
  endtask

  // Continues from the capture of x7=0x33 in test_skip
  task automatic test_src_mismatch();
    retire(0, 1, 32'h0, 7, 32'h34, 0, '0); step();
    checks++; if (chk_fail !== 1'b1 || chk_fail_code !== 2'd1 || chk_fail_chan !== 1'b0) begin
      failures++; $display("FAIL src1_mismatch: got fail %0d code %0d chan %0d want 1/1/0",
                           chk_fail, chk_fail_code, chk_fail_chan); end
    checks++; if (chk_remain !== 8'd15) begin failures++;
      $display("FAIL src1_remain: got %0d want 15", chk_remain); end
  endtask

  task automatic test_overwrite();
    do_reset(); tb_pc = 32'h80;
    check_trig = 1'b1; step();
    retire(0, 7, 32'h33, 0, '0, 0, '0); step();
    retire(0, 7, 32'h44, 0, '0, 0, '0);
    retire(1, 2, 32'h0, 7, 32'h55, 0, '0); step();
    retire(0, 3, 32'h0, 0, '0, 7, 32'h99); step();
    checks++; if (chk_fail !== 1'b0 || chk_state !== 2'd2 || chk_remain !== 8'd13) begin failures++;
      $display("FAIL overwrite: got fail %0d state %0d remain %0d want 0/2/13",
               chk_fail, chk_state, chk_remain); end
  endtask

  task automatic test_pc_break();
    do_reset(); tb_pc = 32'hFC;
    check_trig = 1'b1; step();
    retire(0, 7, 32'h33, 0, '0, 0, '0); step();
    retire(0, 1, 32'h0, 0, '0, 0, '0);
    tb_pc = 32'h200;
    retire(1, 2, 32'h0, 0, '0, 0, '0); step();
`ifdef MFI_PC_CHAIN_EN
    checks++; if (chk_fail !== 1'b1 || chk_fail_code !== 2'd3 || chk_fail_chan !== 1'b1) begin
      failures++; $display("FAIL pc_break: got fail %0d code %0d chan %0d want 1/3/1",
                           chk_fail, chk_fail_code, chk_fail_chan); end
`else
    checks++; if (chk_fail !== 1'b0 || chk_fail_code !== 2'd0) begin
      failures++; $display("FAIL pc_break_off: got fail %0d code %0d want 0/0",
                           chk_fail, chk_fail_code); end
`endif
  endtask

  task automatic test_trap_x0();
    do_reset(); tb_pc = 32'h1000;
    check_trig = 1'b1; check_skip = 8'd1; step();
    retire(0, 4, 32'h1, 0, '0, 0, '0); mfi_trap[0] = 1'b1; step();
    checks++; if (chk_state !== 2'd1 || chk_remain !== 8'd1) begin failures++;
      $display("FAIL trap_nodec: got state %0d remain %0d want 1/1", chk_state, chk_remain); end
    retire(0, 4, 32'h1, 0, '0, 0, '0); step();
    retire(0, 0, 32'h5a, 0, '0, 0, '0); step();
    checks++; if (chk_state !== 2'd2 || chk_remain !== 8'd16) begin failures++;
      $display("FAIL x0_capture: got state %0d remain %0d want 2/16", chk_state, chk_remain); end
    for (int c = 0; c < 7; c++) begin
      retire(0, 1, 32'h0, 0, 32'hdead, 0, 32'h1);
      retire(1, 2, 32'h0, 0, 32'h5a, 0, 32'h7); step();
    end
    checks++; if (chk_state !== 2'd2 || chk_remain !== 8'd2 || chk_fail !== 1'b0) begin failures++;
      $display("FAIL x0_track: got state %0d remain %0d fail %0d want 2/2/0",
               chk_state, chk_remain, chk_fail); end
    retire(0, 1, 32'h0, 0, 32'h3, 0, 32'h4);
    retire(1, 2, 32'h0, 0, 32'h5, 0, 32'h6); step();
    checks++; if (chk_state !== 2'd3 || chk_remain !== 8'd0 || chk_fail !== 1'b0) begin failures++;
      $display("FAIL track_done: got state %0d remain %0d fail %0d want 3/0/0",
               chk_state, chk_remain, chk_fail); end
  endtask

  task automatic test_reset_track();
    do_reset(); tb_pc = 32'h2000;
    check_trig = 1'b1; step();
    retire(0, 7, 32'h33, 0, '0, 0, '0); step();
    retire(0, 1, 32'h0, 7, 32'h34, 0, '0); step();
    reset = 1'b0; check_trig = 1'b1; check_skip = 8'd5; step(); reset = 1'b1;
    checks++; if (chk_state !== 2'd0 || chk_remain !== 8'd0 || chk_fail !== 1'b0 ||
                  chk_fail_code !== 2'd0) begin failures++;
      $display("FAIL reset_mid_track: got state %0d remain %0d fail %0d code %0d want 0/0/0/0",
               chk_state, chk_remain, chk_fail, chk_fail_code); end
    step();
    checks++; if (chk_state !== 2'd0) begin failures++;
      $display("FAIL reset_trig_ignored: got state %0d want 0", chk_state); end
  endtask

  task automatic test_random();
    int s1a, s2a, dest;
    logic [XLEN-1:0] s1d, s2d;
    for (int ep = 0; ep < 30; ep++) begin
      do_reset();
      tb_pc = {$urandom_range(0, 255), 2'b00};
      for (int c = 0; c < 80; c++) begin
        reset      = ($urandom_range(0, 149) != 0);
        check_trig = ($urandom_range(0, 5) == 0);
        check_skip = CNTW'($urandom_range(0, 3));
        for (int k = 0; k < NRET; k++) begin
          if ($urandom_range(0, 3) == 0) continue;
          dest = $urandom_range(0, 3);
          s1a  = $urandom_range(0, 3);
          s2a  = $urandom_range(0, 3);
          s1d  = (s1a == m_addr && $urandom_range(0, 7) != 0) ? m_data : 32'($urandom_range(0, 3));
          s2d  = (s2a == m_addr && $urandom_range(0, 7) != 0) ? m_data : 32'($urandom_range(0, 3));
          if ($urandom_range(0, 15) == 0) tb_pc = tb_pc + 32'd8;
          retire(k, dest, 32'($urandom_range(0, 3)), s1a, s1d, s2a, s2d);
          mfi_trap[k] = ($urandom_range(0, 7) == 0);
        end
        step();
        checks++; if (chk_state !== 2'(m_mode)) begin failures++;
          $display("FAIL rnd_state ep%0d c%0d: got %0d want %0d", ep, c, chk_state, m_mode); end
        checks++; if (chk_remain !== CNTW'(m_cnt)) begin failures++;
          $display("FAIL rnd_remain ep%0d c%0d: got %0d want %0d", ep, c, chk_remain, m_cnt); end
        checks++; if (chk_fail !== m_fail || chk_fail_code !== 2'(m_code) ||
                      chk_fail_chan !== 1'(m_chan)) begin failures++;
          $display("FAIL rnd_fail ep%0d c%0d: got %0d/%0d/%0d want %0d/%0d/%0d", ep, c,
                   chk_fail, chk_fail_code, chk_fail_chan, m_fail, m_code, m_chan); end
      end
    end
  endtask

  initial begin
    clear_in();
    tb_pc = '0;
    test_reset();
    test_skip();
    test_src_mismatch();
    test_overwrite();
    test_pc_break();
    test_trap_x0();
    test_reset_track();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
